// File: rtl/ft_tx_arbiter_pkg.sv
// ft_tx_pkg: shared definitions for the FT transmit arbiter.
//   state_t      - arbiter FSM encoding (IDLE, HDR, SEND)
//   HDR_MARKER   - upper byte of the optional per-packet header word
//   ABORT_CNT_W  - width of the saturating watchdog abort counter
package ft_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [7:0] HDR_MARKER  = 8'h7C;
  localparam int         ABORT_CNT_W = 16;

endpackage

// File: rtl/ft_tx_arbiter_if.sv
// ft_tx_arbiter_if: requester streams plus FT write port.
//   req_valid/req_data/req_last/req_ready - per-requester word handshake,
//     requester i occupies req_data[i*DATA_W +: DATA_W]
//   ui_din/ui_din_be/ui_din_valid/ui_din_full - FT transmit FIFO write port
// modport master: requesters and FT FIFO side (drives requests and full)
// modport slave : the arbiter
interface ft_tx_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         ui_din;
  logic [1:0]                ui_din_be;
  logic                      ui_din_valid;
  logic                      ui_din_full;

  modport master (
    output req_valid, req_data, req_last, ui_din_full,
    input  req_ready, ui_din, ui_din_be, ui_din_valid
  );

  modport slave (
    input  req_valid, req_data, req_last, ui_din_full,
    output req_ready, ui_din, ui_din_be, ui_din_valid
  );
endinterface

// File: rtl/ft_tx_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   i_req    - request vector
//   i_last   - index granted last time; scanning starts at i_last+1
//   o_any    - at least one request present
//   o_winner - first requester found scanning i_last+1, +2, ... mod NUM_REQ
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int GID_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GID_W-1:0]   i_last,
  output logic               o_any,
  output logic [GID_W-1:0]   o_winner
);

  assign o_any = |i_req;

  // Scan from the farthest offset down to the nearest so the nearest
  // asserted requester after i_last is the one left in o_winner.
  always_comb begin
    logic [GID_W-1:0] v_idx;
    v_idx    = '0;
    o_winner = i_last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = GID_W'((int'(i_last) + k) % NUM_REQ);
      if (i_req[v_idx]) o_winner = v_idx;
    end
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: packet-granular round-robin arbiter sharing the FT USB
// write port between NUM_REQ word streams (clk_128M domain).
//   clk_128M, rst_128M - clock, synchronous active-high reset
//   bus (slave)        - requester handshakes and FT write port
//   grant_id           - current or last granted requester
//   busy               - high while not in IDLE
//   abort_count        - saturating count of watchdog aborts
// A grant is held through req_last so packets never interleave.
// Optional build macro FT_TX_ARB_HEADER_EN inserts a header word
// {8'h7C, zero-extended grant_id} before each packet.
module ft_tx_arbiter
  import ft_tx_pkg::*;
#(
  parameter  int NUM_REQ     = 3,
  parameter  int DATA_W      = 16,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int GID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_128M,
  input  logic                   rst_128M,
  ft_tx_arbiter_if.slave         bus,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy,
  output logic [ABORT_CNT_W-1:0] abort_count
);

  localparam int SC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SC_W-1:0] STALL_LAST =
    SC_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GID_W-1:0]       r_grant_id;
  logic [GID_W-1:0]       r_last_grant;
  logic [GID_W-1:0]       w_winner;
  logic                   w_any;
  logic [DATA_W-1:0]      r_dout;
  logic                   r_dvalid;
  logic [DATA_W-1:0]      w_load_data;
  logic                   w_load;
  logic                   w_out_free;
  logic                   w_xfer;
  logic                   w_stall;
  logic                   w_abort;
  logic [SC_W-1:0]        r_stall_cnt;
  logic [ABORT_CNT_W-1:0] r_abort_cnt;
  logic                   w_gnt_valid;
  logic                   w_gnt_last;
  logic [DATA_W-1:0]      w_gnt_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GID_W   (GID_W)
  ) u_pick (
    .i_req    (bus.req_valid),
    .i_last   (r_last_grant),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // Output register can take a word if empty or draining this cycle.
  assign w_out_free  = !r_dvalid || !bus.ui_din_full;
  assign w_gnt_valid = bus.req_valid[r_grant_id];
  assign w_gnt_last  = bus.req_last[r_grant_id];

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GID_W'(i)) w_gnt_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = '0;
    w_load        = 1'b0;
    w_load_data   = w_gnt_data;
    w_xfer        = 1'b0;
    w_stall       = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
`ifdef FT_TX_ARB_HEADER_EN
          w_state_nxt = ST_HDR;
`else
          w_state_nxt = ST_SEND;
`endif
        end
      end
`ifdef FT_TX_ARB_HEADER_EN
      ST_HDR: begin
        w_load_data = DATA_W'({HDR_MARKER, 8'(r_grant_id)});
        if (w_out_free) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
`endif
      ST_SEND: begin
        bus.req_ready[r_grant_id] = w_out_free;
        w_xfer  = w_gnt_valid && w_out_free;
        // Only an absent requester stalls; backpressure from the FIFO does not.
        w_stall = !w_gnt_valid;
        w_load  = w_xfer;
        if (w_xfer && w_gnt_last) begin
          w_state_nxt = ST_IDLE;
        end else if ((TIMEOUT_CYC > 0) && w_stall && (r_stall_cnt == STALL_LAST)) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_128M) begin
    if (rst_128M) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GID_W'(NUM_REQ - 1);
      r_dout       <= '0;
      r_dvalid     <= 1'b0;
      r_stall_cnt  <= '0;
      r_abort_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_IDLE) && w_any) begin
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
      end

      // Hold while full; drop valid after acceptance unless reloaded.
      if (w_load) begin
        r_dout   <= w_load_data;
        r_dvalid <= 1'b1;
      end else if (!bus.ui_din_full) begin
        r_dvalid <= 1'b0;
      end

      if ((r_state != ST_SEND) || w_xfer) begin
        r_stall_cnt <= '0;
      end else if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (w_abort && (r_abort_cnt != '1)) begin
        r_abort_cnt <= r_abort_cnt + 1'b1;
      end
    end
  end

  assign bus.ui_din       = r_dout;
  assign bus.ui_din_valid = r_dvalid;
  assign bus.ui_din_be    = 2'b11;
  assign grant_id         = r_grant_id;
  assign busy             = (r_state != ST_IDLE);
  assign abort_count      = r_abort_cnt;

endmodule
